// File: rtl/npu_dec_pkg.sv
// rtl/npu_dec_pkg.sv - shared types and constants for the NPU instruction decoder
//
// Purpose: opcode and FSM state enums, default parameter values, the position
// of the burst beat-count field inside func, and the instruction width helper.
// Ports: none (package).
// Optional feature macro: NPU_DEC_BURST_EN (consumed by the decoder files).

package npu_dec_pkg;

  localparam int DEF_TAG_W     = 4;
  localparam int DEF_TAG_VALUE = 1;
  localparam int DEF_OPC_W     = 6;
  localparam int DEF_FUNC_W    = 10;
  localparam int DEF_ADDR_W    = 22;
  localparam int DEF_RESIZE_W  = 11;
  localparam int DEF_ERR_CNT_W = 16;

  // Burst length lives in func[7:0]; beats = value + 1.
  localparam int BURST_CNT_LSB = 0;
  localparam int BURST_CNT_W   = 8;

  typedef enum logic [DEF_OPC_W-1:0] {
    OPC_MEM   = 6'd0,
    OPC_IMG   = 6'd1,
    OPC_BURST = 6'd2
  } opcode_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } dec_state_e;

  function automatic int instr_width(input int tag_w, input int opc_w,
                                     input int func_w, input int addr_w);
    return tag_w + opc_w + func_w + 2 * addr_w;
  endfunction

endpackage

// File: rtl/npu_instr_decoder_if.sv
// rtl/npu_instr_decoder_if.sv - instruction-in / micro-op-out bundle of the decoder
//
// Purpose: groups the fetch-side instruction handshake, the execution-side
// micro-op handshake and the illegal-instruction status.
// Signals: in_valid/in_ready/in_instr (fetch), out_valid/out_ready/out_* (micro-op),
//          illegal/illegal_count (status).
// Modports: slave = decoder, master = surrounding pipeline.
// Optional feature macro: NPU_DEC_BURST_EN (no effect on this bundle).

interface npu_instr_decoder_if
  import npu_dec_pkg::*;
#(
  parameter int TAG_W     = DEF_TAG_W,
  parameter int OPC_W     = DEF_OPC_W,
  parameter int FUNC_W    = DEF_FUNC_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RESIZE_W  = DEF_RESIZE_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) ();

  localparam int INSTR_W = instr_width(TAG_W, OPC_W, FUNC_W, ADDR_W);

  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   in_instr;

  logic                 out_valid;
  logic                 out_ready;
  logic [OPC_W-1:0]     out_opcode;
  logic [FUNC_W-1:0]    out_func;
  logic [ADDR_W-1:0]    out_addr_a;
  logic [ADDR_W-1:0]    out_addr_b;
  logic [ADDR_W-1:0]    out_img_reg;
  logic [RESIZE_W-1:0]  out_resize_1;
  logic [RESIZE_W-1:0]  out_resize_2;
  logic                 out_last;

  logic                 illegal;
  logic [ERR_CNT_W-1:0] illegal_count;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_func, out_addr_a, out_addr_b,
           out_img_reg, out_resize_1, out_resize_2, out_last, illegal, illegal_count
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_func, out_addr_a, out_addr_b,
           out_img_reg, out_resize_1, out_resize_2, out_last, illegal, illegal_count
  );

endinterface

// File: rtl/npu_dec_field_split.sv
// rtl/npu_dec_field_split.sv - combinational tag/opcode check and field extraction
//
// Purpose: slices an instruction word (tag, opcode, func, field A, field B, MSB
// first), splits field B into the two resize fields and flags legal words.
// Ports: instr (in) -> opcode, func, field_a, field_b, resize_1, resize_2, legal (out).
// Optional feature macro: NPU_DEC_BURST_EN (opcode 2 legal only when defined).

module npu_dec_field_split
  import npu_dec_pkg::*;
#(
  parameter int TAG_W     = DEF_TAG_W,
  parameter int TAG_VALUE = DEF_TAG_VALUE,
  parameter int OPC_W     = DEF_OPC_W,
  parameter int FUNC_W    = DEF_FUNC_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RESIZE_W  = DEF_RESIZE_W,
  parameter int INSTR_W   = instr_width(TAG_W, OPC_W, FUNC_W, ADDR_W)
) (
  input  logic [INSTR_W-1:0]  instr,
  output logic [OPC_W-1:0]    opcode,
  output logic [FUNC_W-1:0]   func,
  output logic [ADDR_W-1:0]   field_a,
  output logic [ADDR_W-1:0]   field_b,
  output logic [RESIZE_W-1:0] resize_1,
  output logic [RESIZE_W-1:0] resize_2,
  output logic                legal
);

  logic [TAG_W-1:0] tag;
  logic             tag_ok;

  assign {tag, opcode, func, field_a, field_b} = instr;

  assign resize_1 = field_b[ADDR_W-1 -: RESIZE_W];
  assign resize_2 = field_b[RESIZE_W-1:0];

  assign tag_ok = (tag == TAG_W'(TAG_VALUE));

  always_comb begin
    legal = 1'b0;
    if (opcode == OPC_W'(OPC_MEM) || opcode == OPC_W'(OPC_IMG)) begin
      legal = tag_ok;
    end
`ifdef NPU_DEC_BURST_EN
    if (opcode == OPC_W'(OPC_BURST)) begin
      legal = tag_ok;
    end
`endif
  end

endmodule

// File: rtl/npu_instr_decoder.sv
// rtl/npu_instr_decoder.sv - handshaked NPU instruction decoder with burst expansion
//
// Purpose: accepts tagged instruction words, presents one registered micro-op
// per cycle, expands BURST into address-incrementing MEM beats and counts
// rejected words with a saturating counter.
// Ports: clk, rst_n (async, active-low), bus (npu_instr_decoder_if.slave).
// Optional feature macro: NPU_DEC_BURST_EN (BURST opcode and BURST state).

module npu_instr_decoder
  import npu_dec_pkg::*;
#(
  parameter int TAG_W     = DEF_TAG_W,
  parameter int TAG_VALUE = DEF_TAG_VALUE,
  parameter int OPC_W     = DEF_OPC_W,
  parameter int FUNC_W    = DEF_FUNC_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RESIZE_W  = DEF_RESIZE_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  npu_instr_decoder_if.slave bus
);

  logic [OPC_W-1:0]    f_opcode;
  logic [FUNC_W-1:0]   f_func;
  logic [ADDR_W-1:0]   f_a, f_b;
  logic [RESIZE_W-1:0] f_r1, f_r2;
  logic                f_legal;

  npu_dec_field_split #(
    .TAG_W(TAG_W), .TAG_VALUE(TAG_VALUE), .OPC_W(OPC_W), .FUNC_W(FUNC_W),
    .ADDR_W(ADDR_W), .RESIZE_W(RESIZE_W)
  ) u_split (
    .instr(bus.in_instr), .opcode(f_opcode), .func(f_func), .field_a(f_a),
    .field_b(f_b), .resize_1(f_r1), .resize_2(f_r2), .legal(f_legal)
  );

  dec_state_e           state_q, state_d;
  logic                 valid_q, valid_d;
  logic [OPC_W-1:0]     opcode_q, opcode_d;
  logic [FUNC_W-1:0]    func_q, func_d;
  logic [ADDR_W-1:0]    addr_a_q, addr_a_d, addr_b_q, addr_b_d, img_q, img_d;
  logic [RESIZE_W-1:0]  r1_q, r1_d, r2_q, r2_d;
  logic                 last_q, last_d;
  logic                 illegal_q, illegal_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

`ifdef NPU_DEC_BURST_EN
  // Address pair and beat budget for the next beat still to be loaded.
  logic [ADDR_W-1:0]      burst_a_q, burst_a_d, burst_b_q, burst_b_d;
  logic [FUNC_W-1:0]      burst_func_q, burst_func_d;
  logic [BURST_CNT_W-1:0] burst_rem_q, burst_rem_d;
`endif

  logic load_en;
  logic in_ready;
  logic accept;

  // The output register may take a new value whenever it is empty or draining.
  assign load_en  = !valid_q || bus.out_ready;
  assign in_ready = (state_q == ST_IDLE) && load_en;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    func_d    = func_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    img_d     = img_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    last_d    = last_q;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
`ifdef NPU_DEC_BURST_EN
    burst_a_d    = burst_a_q;
    burst_b_d    = burst_b_q;
    burst_func_d = burst_func_q;
    burst_rem_d  = burst_rem_q;
`endif

    if (load_en) begin
      // Unused fields are zeroed on every load so they never carry stale data.
      valid_d  = 1'b0;
      opcode_d = '0;
      func_d   = '0;
      addr_a_d = '0;
      addr_b_d = '0;
      img_d    = '0;
      r1_d     = '0;
      r2_d     = '0;
      last_d   = 1'b0;

      if (state_q == ST_IDLE) begin
        if (accept) begin
          if (f_legal) begin
            valid_d  = 1'b1;
            opcode_d = f_opcode;
            func_d   = f_func;
            last_d   = 1'b1;
            if (f_opcode == OPC_W'(OPC_IMG)) begin
              img_d = f_a;
              r1_d  = f_r1;
              r2_d  = f_r2;
            end else begin
              addr_a_d = f_a;
              addr_b_d = f_b;
            end
`ifdef NPU_DEC_BURST_EN
            if (f_opcode == OPC_W'(OPC_BURST)) begin
              // First beat goes out now; the count field is exactly the
              // number of beats left after it.
              opcode_d     = OPC_W'(OPC_MEM);
              burst_func_d = f_func;
              burst_a_d    = f_a + ADDR_W'(1);
              burst_b_d    = f_b + ADDR_W'(1);
              burst_rem_d  = f_func[BURST_CNT_LSB +: BURST_CNT_W];
              if (f_func[BURST_CNT_LSB +: BURST_CNT_W] != '0) begin
                last_d  = 1'b0;
                state_d = ST_BURST;
              end
            end
`endif
          end else begin
            illegal_d = 1'b1;
            if (cnt_q != {ERR_CNT_W{1'b1}}) begin
              cnt_d = cnt_q + ERR_CNT_W'(1);
            end
          end
        end
      end
`ifdef NPU_DEC_BURST_EN
      else begin
        valid_d     = 1'b1;
        opcode_d    = OPC_W'(OPC_MEM);
        func_d      = burst_func_q;
        addr_a_d    = burst_a_q;
        addr_b_d    = burst_b_q;
        last_d      = (burst_rem_q == BURST_CNT_W'(1));
        burst_a_d   = burst_a_q + ADDR_W'(1);
        burst_b_d   = burst_b_q + ADDR_W'(1);
        burst_rem_d = burst_rem_q - BURST_CNT_W'(1);
        if (burst_rem_q == BURST_CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      func_q    <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      img_q     <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      func_q    <= func_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      img_q     <= img_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      last_q    <= last_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef NPU_DEC_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_a_q    <= '0;
      burst_b_q    <= '0;
      burst_func_q <= '0;
      burst_rem_q  <= '0;
    end else begin
      burst_a_q    <= burst_a_d;
      burst_b_q    <= burst_b_d;
      burst_func_q <= burst_func_d;
      burst_rem_q  <= burst_rem_d;
    end
  end
`endif

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_opcode    = opcode_q;
  assign bus.out_func      = func_q;
  assign bus.out_addr_a    = addr_a_q;
  assign bus.out_addr_b    = addr_b_q;
  assign bus.out_img_reg   = img_q;
  assign bus.out_resize_1  = r1_q;
  assign bus.out_resize_2  = r2_q;
  assign bus.out_last      = last_q;
  assign bus.illegal       = illegal_q;
  assign bus.illegal_count = cnt_q;

endmodule

// File: tb/tb_npu_instr_decoder.sv
// tb/tb_npu_instr_decoder.sv - randomized self-checking bench for npu_instr_decoder
//
// Purpose: drives directed and random instruction words and compares every
// micro-op, handshake and illegal-status value with a queue-based model.
// Ports: none (top-level bench).
// Optional feature macro: NPU_DEC_BURST_EN (selects the model's BURST behaviour).

module tb_npu_instr_decoder;
  import npu_dec_pkg::*;

  localparam int TAG_W     = 4;
  localparam int TAG_VALUE = 1;
  localparam int OPC_W     = 6;
  localparam int FUNC_W    = 10;
  localparam int ADDR_W    = 22;
  localparam int RESIZE_W  = 11;
  localparam int ERR_CNT_W = 4;
  localparam int INSTR_W   = TAG_W + OPC_W + FUNC_W + 2 * ADDR_W;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
  localparam int ADDR_MOD  = 1 << ADDR_W;

`ifdef NPU_DEC_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef struct {
    int unsigned opc;
    int unsigned func;
    int unsigned a;
    int unsigned b;
    int unsigned img;
    int unsigned r1;
    int unsigned r2;
    bit          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  npu_instr_decoder_if #(
    .TAG_W(TAG_W), .OPC_W(OPC_W), .FUNC_W(FUNC_W), .ADDR_W(ADDR_W),
    .RESIZE_W(RESIZE_W), .ERR_CNT_W(ERR_CNT_W)
  ) bus ();

  npu_instr_decoder #(
    .TAG_W(TAG_W), .TAG_VALUE(TAG_VALUE), .OPC_W(OPC_W), .FUNC_W(FUNC_W),
    .ADDR_W(ADDR_W), .RESIZE_W(RESIZE_W), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  beat_t              exp_q[$];
  logic [INSTR_W-1:0] stim_q[$];
  logic [INSTR_W-1:0] cur_word;
  bit                 have_word = 0;
  bit                 illegal_pend = 0;
  int unsigned        cnt_exp = 0;
  int                 valid_pct = 100;
  int                 ready_pct = 100;
  int                 beats_popped = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input int unsigned tag, input int unsigned opc,
                                            input int unsigned func, input int unsigned a,
                                            input int unsigned b);
    return {4'(tag), 6'(opc), 10'(func), 22'(a), 22'(b)};
  endfunction

  // Reference behaviour: decode by arithmetic on the word and queue every beat.
  task automatic model_accept(input logic [INSTR_W-1:0] w);
    longint unsigned v;
    int unsigned tag, opc, func, a, b, n;
    beat_t bt;
    v    = w;
    tag  = int'(v >> 60);
    opc  = int'((v >> 54) % 64);
    func = int'((v >> 44) % 1024);
    a    = int'((v >> 22) % ADDR_MOD);
    b    = int'(v % ADDR_MOD);
    if (tag != TAG_VALUE || !(opc == 0 || opc == 1 || (opc == 2 && BURST_EN))) begin
      illegal_pend = 1;
      if (cnt_exp < CNT_MAX) cnt_exp++;
      return;
    end
    bt = '{opc: opc, func: func, a: 0, b: 0, img: 0, r1: 0, r2: 0, last: 1'b1};
    if (opc == 0) begin
      bt.a = a;
      bt.b = b;
      exp_q.push_back(bt);
    end else if (opc == 1) begin
      bt.img = a;
      bt.r1  = b / 2048;
      bt.r2  = b % 2048;
      exp_q.push_back(bt);
    end else begin
      n = func % 256 + 1;
      for (int k = 0; k < n; k++) begin
        bt.opc  = 0;
        bt.a    = (a + k) % ADDR_MOD;
        bt.b    = (b + k) % ADDR_MOD;
        bt.last = (k == n - 1);
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic evaluate();
    beat_t e;
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("in_ready", bus.in_ready, (exp_q.size() <= 1) && (exp_q.size() == 0 || bus.out_ready));
    check("illegal", bus.illegal, illegal_pend);
    check("illegal_count", bus.illegal_count, cnt_exp);
    illegal_pend = 0;
    if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("beat", {bus.out_opcode, bus.out_func, bus.out_addr_a, bus.out_addr_b,
                     bus.out_img_reg, bus.out_resize_1, bus.out_resize_2, bus.out_last},
            {6'(e.opc), 10'(e.func), 22'(e.a), 22'(e.b), 22'(e.img), 11'(e.r1),
             11'(e.r2), e.last});
      beats_popped++;
    end
    if (bus.in_valid && bus.in_ready) begin
      model_accept(cur_word);
      have_word = 0;
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    if (!have_word && stim_q.size() != 0 && $urandom_range(99) < valid_pct) begin
      cur_word  = stim_q.pop_front();
      have_word = 1;
    end
    bus.in_valid  = have_word;
    bus.in_instr  = have_word ? cur_word : {$urandom, $urandom};
    bus.out_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    evaluate();
  endtask

  task automatic run_until_idle(input int cap);
    int n = 0;
    while ((stim_q.size() != 0 || have_word || exp_q.size() != 0 || illegal_pend) && n < cap) begin
      run_cycle();
      n++;
    end
    if (n >= cap) check("drain_timeout", 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_opcode", bus.out_opcode, '0);
    check("rst_func", bus.out_func, '0);
    check("rst_addr_a", bus.out_addr_a, '0);
    check("rst_addr_b", bus.out_addr_b, '0);
    check("rst_img_reg", bus.out_img_reg, '0);
    check("rst_resize", {bus.out_resize_1, bus.out_resize_2}, '0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_illegal", bus.illegal, 1'b0);
    check("rst_illegal_count", bus.illegal_count, '0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    stim_q.delete();
    have_word    = 0;
    illegal_pend = 0;
    cnt_exp      = 0;
    bus.in_valid = 1'b0;
    repeat (2) run_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned tag, opc, func, a, b, sel;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;

    // Reset state, then release and idle.
    apply_reset();
    repeat (3) run_cycle();

    // Single MEM and IMG words.
    stim_q.push_back(mk(1, 0, 0, 'hABC, 'h123));
    stim_q.push_back(mk(1, 1, 'h3A, 'h55, ('h10 << 11) | 'h20));
    run_until_idle(50);

    // Wrapping burst under random output stalls.
    ready_pct = 50;
    stim_q.push_back(mk(1, 2, 3, 'h3FFFFE, 0));
    run_until_idle(100);

    // Bad tag, then unknown opcode.
    ready_pct = 100;
    stim_q.push_back(mk(2, 0, 0, 1, 2));
    stim_q.push_back(mk(1, 5, 0, 3, 4));
    run_until_idle(50);

    // Ten back-to-back MEM words at full rate.
    for (int i = 0; i < 10; i++) stim_q.push_back(mk(1, 0, i, 'h100 + i, 'h200 + i));
    run_until_idle(50);

    // Maximum-length burst.
    stim_q.push_back(mk(1, 2, 'h3FF, 'h3FFF80, 'h10));
    run_until_idle(400);

    // Random mix with random valid/ready.
    valid_pct = 70;
    ready_pct = 70;
    for (int i = 0; i < 200; i++) begin
      tag  = ($urandom_range(9) == 0) ? $urandom_range(15) : TAG_VALUE;
      sel  = $urandom_range(9);
      opc  = (sel < 4) ? 0 : (sel < 7) ? 1 : (sel < 9) ? 2 : $urandom_range(63);
      func = $urandom_range(1023);
      if (opc == 2) func = (func & 'h300) | $urandom_range(6);
      a    = $urandom_range(ADDR_MOD - 1);
      b    = $urandom_range(ADDR_MOD - 1);
      if ($urandom_range(3) == 0) a = ADDR_MOD - 1 - $urandom_range(3);
      stim_q.push_back(mk(tag, opc, func, a, b));
    end
    run_until_idle(4000);

    // Counter saturation.
    valid_pct = 100;
    for (int i = 0; i < CNT_MAX + 5; i++) stim_q.push_back(mk(1, 7, 0, i, i));
    run_until_idle(100);
    check("illegal_count_sat", bus.illegal_count, CNT_MAX);

    // Reset while beat 3 of an 8-beat burst sits in the output register.
    ready_pct    = 100;
    beats_popped = 0;
    stim_q.push_back(mk(1, 2, 7, 'h40, 'h80));
    for (int i = 0; i < 20 && beats_popped < 2 && (stim_q.size() != 0 || have_word || exp_q.size() != 0); i++) begin
      run_cycle();
    end
    @(posedge clk);
    #2;
    apply_reset();
    repeat (5) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npu_instr_decoder.md
# npu_instr_decoder

Parametrised, handshaked instruction decoder for the NPU front end: accepts tagged instruction words from the fetch stage, splits them into memory/image operand fields, and presents one registered micro-op per cycle to the execution units. Adds a burst-memory opcode that expands into a sequence of address-incrementing memory micro-ops. Rejected words are counted and flagged instead of producing undefined outputs.

## Interface
- TAG_W, 4, header tag width (instr MSBs)
- TAG_VALUE, 1, tag marking a valid instruction
- OPC_W, 6, opcode width
- FUNC_W, 10, function field width (≥ 8)
- ADDR_W, 22, operand field width; INSTR_W = TAG_W+OPC_W+FUNC_W+2*ADDR_W
- RESIZE_W, 11, resize field width; must equal ADDR_W/2
- ERR_CNT_W, 16, illegal-instruction counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid / in_ready  in / out  1  instruction handshake
- in_instr  in  INSTR_W  instruction word
- out_valid / out_ready  out / in  1  micro-op handshake
- out_opcode  out  OPC_W  decoded opcode
- out_func  out  FUNC_W  function field, passed through
- out_addr_a  out  ADDR_W  store/load address (memory, burst)
- out_addr_b  out  ADDR_W  data register/address (memory, burst)
- out_img_reg  out  ADDR_W  image buffer register (image)
- out_resize_1 / out_resize_2  out  RESIZE_W  resize registers (image)
- out_last  out  1  final micro-op of an instruction (always 1 for non-burst)
- illegal  out  1  one-cycle pulse per rejected instruction
- illegal_count  out  ERR_CNT_W  saturating count of rejected instructions

## Operation
- Field layout, MSB first: tag, opcode, func, field A, field B; image ops split field B into resize_1 (upper RESIZE_W) and resize_2 (lower).
- Opcodes: 0 = MEM, 1 = IMG, 2 = BURST. Tag ≠ TAG_VALUE or any other opcode → illegal.
- Fields not used by the current opcode are driven 0, never X.
- MEM: addr_a = field A, addr_b = field B, out_last = 1.
- IMG: img_reg = field A, resize fields from B, out_last = 1.
- BURST: beats = func[7:0]+1 (1..256). Beat k: addr_a = A+k, addr_b = B+k, both modulo 2^ADDR_W (wrap to 0); out_opcode = 0 (MEM), out_func = original func; out_last = 1 on final beat only.
- Illegal word: consumed (in_ready honoured), no micro-op, illegal pulses next cycle, illegal_count increments, holds at all-ones.
- FSM: IDLE (accept new word) and BURST (issue beats 2..N). Accepting a BURST with beats>1 → BURST; after loading final beat into the output register → IDLE.

## Timing
- Reset: state IDLE, out_valid 0, all data outputs 0, out_last 0, illegal 0, illegal_count 0; in-flight burst abandoned.
- Latency: accepted word → out_valid next cycle.
- in_ready = (state == IDLE) && (!out_valid || out_ready); combinational from out_ready; back-to-back single ops at 1/cycle.
- Output register holds all out_* stable while out_valid && !out_ready.
- BURST: one beat per cycle while out_ready high; stalls without loss; in_ready 0 throughout.
- Illegal word accepted in the same cycle the output drains: output register updates to out_valid 0 normally.

## Configuration
- NPU_DEC_BURST_EN defined: BURST opcode and BURST state present.
- Undefined: opcode 2 is illegal; FSM reduces to IDLE only; out_last constant 1 when out_valid.

## Structure
- Package npu_dec_pkg: opcode enum (OPC_MEM, OPC_IMG, OPC_BURST), state enum, default parameter constants, burst-count field position.
- Sub-module npu_dec_field_split: combinational tag/opcode check and field extraction, instantiated once by the top.

## Test plan
- Reset mid-burst: rst_n low during beat 3 of 8 → all outputs 0, in_ready 1 after release, no further beats.
- MEM 0x1_00_000_0000ABC_0000123 style word with out_ready=1 → one beat, addr_a=0xABC, addr_b=0x123, out_last=1, image fields 0.
- IMG word, field A=0x55, B = resize_1 0x10 / resize_2 0x20 → img_reg=0x55, resize_1=0x10, resize_2=0x20, addr fields 0.
- BURST func[7:0]=3, A=0x3FFFFE, B=0 with random out_ready stalls → 4 beats, addr_a 0x3FFFFE,0x3FFFFF,0,1, addr_b 0..3, out_last on beat 4 only, in_ready 0 until final beat loaded.
- Tag=2 word, then opcode 5 word → two illegal pulses, illegal_count=2, no out_valid; preload count to all-ones → stays all-ones.
- Back-to-back 10 MEM words with out_ready=1 → 10 outputs on 10 consecutive cycles, order preserved; build without NPU_DEC_BURST_EN → opcode 2 flagged illegal.
